// File: rtl/user_io_arbiter.sv
// user_io_arbiter
//   Shares the S-edge IO tile user output word (UOUT) between NREQ fabric-side
//   requesters. One requester owns the output at a time. Ownership is granted
//   round-robin. A burst ends on the owner's last beat, after MAX_BURST
//   accepted beats, or after IDLE_TIMEOUT granted cycles with no accepted beat.
//   The asynchronous user input word UIN is also brought into the CLK domain.
//
// Ports
//   CLK         fabric clock
//   resetn      asynchronous active-low reset
//   req_valid   per-requester word valid
//   req_last    per-requester last beat of burst (qualified by req_valid)
//   req_data    requester i data in bits [i*WIDTH +: WIDTH]
//   req_ready   per-requester accept (only the owner can see a 1)
//   grant       one-hot current owner, all-zero when idle
//   busy        high while a grant is held
//   UOUT        registered word to the user project
//   uout_valid  UOUT holds an unconsumed word
//   uout_ready  user project accepts UOUT
//   UIN         asynchronous user input word
//   uin_sync    UIN after a 2-flop synchroniser
module user_io_arbiter #(
    parameter int unsigned WIDTH        = 20,
    parameter int unsigned NREQ         = 4,
    parameter int unsigned MAX_BURST    = 8,
    parameter int unsigned IDLE_TIMEOUT = 4
) (
    input  logic                    CLK,
    input  logic                    resetn,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ-1:0]         req_last,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic [NREQ-1:0]         grant,
    output logic                    busy,
    output logic [WIDTH-1:0]        UOUT,
    output logic                    uout_valid,
    input  logic                    uout_ready,
    input  logic [WIDTH-1:0]        UIN,
    output logic [WIDTH-1:0]        uin_sync
);

    localparam int unsigned   PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0]    MAXB     = 8'(MAX_BURST);
    localparam logic [7:0]    IDLE_LIM = 8'(IDLE_TIMEOUT);
    localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [7:0]        beat_q, beat_d;
    logic [7:0]        idle_q, idle_d;
    logic [WIDTH-1:0]  uout_q, uout_d;
    logic              uvalid_q, uvalid_d;
    logic [WIDTH-1:0]  sync1_q, sync2_q;

    logic              pick_found;
    logic [PW-1:0]     pick_idx;
    logic [PW:0]       cand;
    logic [WIDTH-1:0]  sel_data;
    logic              sel_valid;
    logic              sel_last;
    logic              out_free;
    logic              xfer;
    logic              rel;

    // Round-robin pick: scan ptr, ptr+1, ... (mod NREQ); first asserted valid wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_q} + (PW+1)'(k);
            if (cand >= (PW+1)'(NREQ)) begin
                cand = cand - (PW+1)'(NREQ);
            end
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!pick_found && req_valid[i] && (cand == (PW+1)'(i))) begin
                    pick_found = 1'b1;
                    pick_idx   = PW'(i);
                end
            end
        end
    end

    // Owner's lane.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (owner_q == PW'(i)) begin
                sel_data  = req_data[i*WIDTH +: WIDTH];
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
            end
        end
    end

    // The output register can take a word when empty or being drained this cycle.
    assign out_free = ~uvalid_q | uout_ready;
    assign xfer     = (state_q == ST_GRANT) & sel_valid & out_free;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        grant_d  = grant_q;
        beat_d   = beat_q;
        idle_d   = idle_q;
        uout_d   = uout_q;
        uvalid_d = uvalid_q;
        rel      = 1'b0;

        // Output register drains independently of ownership changes.
        if (uvalid_q && uout_ready) begin
            uvalid_d = 1'b0;
        end
        if (xfer) begin
            uout_d   = sel_data;
            uvalid_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_GRANT;
                    owner_d = pick_idx;
                    beat_d  = '0;
                    idle_d  = '0;
                    for (int unsigned i = 0; i < NREQ; i++) begin
                        grant_d[i] = (pick_idx == PW'(i));
                    end
                end
            end
            ST_GRANT: begin
                if (xfer) begin
                    beat_d = beat_q + 8'd1;
                    idle_d = '0;
                    rel    = sel_last | ((beat_q + 8'd1) == MAXB);
                end else begin
                    idle_d = idle_q + 8'd1;
                    rel    = ((idle_q + 8'd1) == IDLE_LIM);
                end
                if (rel) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = (owner_q == LAST_IDX) ? '0 : owner_q + PW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            grant_q  <= '0;
            beat_q   <= '0;
            idle_q   <= '0;
            uout_q   <= '0;
            uvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            grant_q  <= grant_d;
            beat_q   <= beat_d;
            idle_q   <= idle_d;
            uout_q   <= uout_d;
            uvalid_q <= uvalid_d;
        end
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= UIN;
            sync2_q <= sync1_q;
        end
    end

    assign grant      = grant_q;
    assign busy       = (state_q == ST_GRANT);
    assign req_ready  = grant_q & {NREQ{out_free}};
    assign UOUT       = uout_q;
    assign uout_valid = uvalid_q;
    assign uin_sync   = sync2_q;

endmodule

// File: tb/tb_user_io_arbiter.sv
// tb_user_io_arbiter
//   Directed bench for user_io_arbiter (WIDTH=20, NREQ=4, MAX_BURST=8,
//   IDLE_TIMEOUT=4). Inputs change at the falling edge; outputs are sampled
//   1 time unit later, i.e. values seen during the cycle before the next
//   rising edge.
module tb_user_io_arbiter;

    logic        CLK = 1'b0;
    logic        resetn;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [79:0] req_data;
    logic [3:0]  req_ready;
    logic [3:0]  grant;
    logic        busy;
    logic [19:0] UOUT;
    logic        uout_valid;
    logic        uout_ready;
    logic [19:0] UIN;
    logic [19:0] uin_sync;

    int pass_cnt  = 0;
    int total_cnt = 0;

    user_io_arbiter #(
        .WIDTH(20),
        .NREQ(4),
        .MAX_BURST(8),
        .IDLE_TIMEOUT(4)
    ) dut (
        .CLK(CLK),
        .resetn(resetn),
        .req_valid(req_valid),
        .req_last(req_last),
        .req_data(req_data),
        .req_ready(req_ready),
        .grant(grant),
        .busy(busy),
        .UOUT(UOUT),
        .uout_valid(uout_valid),
        .uout_ready(uout_ready),
        .UIN(UIN),
        .uin_sync(uin_sync)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0]  rv;
        logic [3:0]  rl;
        logic [19:0] dat;     // owner lane data; non-valid lanes get ~dat
        logic        ur;
        logic [3:0]  e_gnt;
        logic [3:0]  e_rdy;
        logic        e_uv;
        logic [19:0] e_uout;
        logic        e_busy;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_grant"}, 32'(grant), 32'h0);
        check({tag, "_busy"},  32'(busy), 32'h0);
        check({tag, "_ready"}, 32'(req_ready), 32'h0);
        check({tag, "_uv"},    32'(uout_valid), 32'h0);
        check({tag, "_uout"},  32'(UOUT), 32'h0);
    endtask

    task automatic reset_pulse();
        @(negedge CLK);
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        resetn    = 1'b0;
        @(negedge CLK);
        resetn    = 1'b1;
    endtask

    initial begin
        int          order [3];
        logic [3:0]  bcnt;
        int          n;
        logic [19:0] rx [$];
        logic [19:0] got;
        int          own;

        order = '{0, 2, 3};

        // Single burst from requester 1 (rows 0-5), then requester 0 with
        // 5 cycles of backpressure that also trips the idle timeout (rows 6-16).
        vecs[0]  = '{4'b0010, 4'b0000, 20'h00001, 1'b1, 4'b0000, 4'b0000, 1'b0, 20'h00000, 1'b0};
        vecs[1]  = '{4'b0010, 4'b0000, 20'h00001, 1'b1, 4'b0010, 4'b0010, 1'b0, 20'h00000, 1'b1};
        vecs[2]  = '{4'b0010, 4'b0000, 20'h00002, 1'b1, 4'b0010, 4'b0010, 1'b1, 20'h00001, 1'b1};
        vecs[3]  = '{4'b0010, 4'b0010, 20'h00003, 1'b1, 4'b0010, 4'b0010, 1'b1, 20'h00002, 1'b1};
        vecs[4]  = '{4'b0000, 4'b0000, 20'h00000, 1'b1, 4'b0000, 4'b0000, 1'b1, 20'h00003, 1'b0};
        vecs[5]  = '{4'b0000, 4'b0000, 20'h00000, 1'b1, 4'b0000, 4'b0000, 1'b0, 20'h00003, 1'b0};
        vecs[6]  = '{4'b0001, 4'b0000, 20'h0000A, 1'b1, 4'b0000, 4'b0000, 1'b0, 20'h00003, 1'b0};
        vecs[7]  = '{4'b0001, 4'b0000, 20'h0000A, 1'b0, 4'b0001, 4'b0001, 1'b0, 20'h00003, 1'b1};
        vecs[8]  = '{4'b0001, 4'b0000, 20'h0000B, 1'b0, 4'b0001, 4'b0000, 1'b1, 20'h0000A, 1'b1};
        vecs[9]  = '{4'b0001, 4'b0000, 20'h0000B, 1'b0, 4'b0001, 4'b0000, 1'b1, 20'h0000A, 1'b1};
        vecs[10] = '{4'b0001, 4'b0000, 20'h0000B, 1'b0, 4'b0001, 4'b0000, 1'b1, 20'h0000A, 1'b1};
        vecs[11] = '{4'b0001, 4'b0000, 20'h0000B, 1'b0, 4'b0001, 4'b0000, 1'b1, 20'h0000A, 1'b1};
        vecs[12] = '{4'b0001, 4'b0000, 20'h0000B, 1'b1, 4'b0000, 4'b0000, 1'b1, 20'h0000A, 1'b0};
        vecs[13] = '{4'b0001, 4'b0000, 20'h0000B, 1'b1, 4'b0001, 4'b0001, 1'b0, 20'h0000A, 1'b1};
        vecs[14] = '{4'b0001, 4'b0001, 20'h0000C, 1'b1, 4'b0001, 4'b0001, 1'b1, 20'h0000B, 1'b1};
        vecs[15] = '{4'b0000, 4'b0000, 20'h00000, 1'b1, 4'b0000, 4'b0000, 1'b1, 20'h0000C, 1'b0};
        vecs[16] = '{4'b0000, 4'b0000, 20'h00000, 1'b1, 4'b0000, 4'b0000, 1'b0, 20'h0000C, 1'b0};

        resetn     = 1'b0;
        req_valid  = '0;
        req_last   = '0;
        req_data   = '0;
        uout_ready = 1'b1;
        UIN        = '0;

        // Reset state, then 10 idle cycles.
        repeat (2) @(negedge CLK);
        #1;
        check_cleared("rst");
        check("rst_sync", 32'(uin_sync), 32'h0);
        resetn = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            #1;
            check_cleared($sformatf("idle%0d", c));
        end

        // Table-driven vectors.
        for (int r = 0; r < 17; r++) begin
            @(negedge CLK);
            req_valid  = vecs[r].rv;
            req_last   = vecs[r].rl;
            uout_ready = vecs[r].ur;
            for (int i = 0; i < 4; i++) begin
                req_data[i*20 +: 20] = vecs[r].rv[i] ? vecs[r].dat : ~vecs[r].dat;
            end
            #1;
            check($sformatf("v%0d_grant", r), 32'(grant), 32'(vecs[r].e_gnt));
            check($sformatf("v%0d_ready", r), 32'(req_ready), 32'(vecs[r].e_rdy));
            check($sformatf("v%0d_uv", r), 32'(uout_valid), 32'(vecs[r].e_uv));
            check($sformatf("v%0d_uout", r), 32'(UOUT), 32'(vecs[r].e_uout));
            check($sformatf("v%0d_busy", r), 32'(busy), 32'(vecs[r].e_busy));
        end

        // Round-robin: requesters 0,2,3 always valid, 2-beat bursts.
        // Period of 3 cycles: bubble, beat0, beat1.
        reset_pulse();
        uout_ready = 1'b1;
        bcnt = '0;
        for (int c = 0; c < 18; c++) begin
            @(negedge CLK);
            req_valid = 4'b1101;
            req_data  = '0;
            req_last  = '0;
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i]) begin
                    req_data[i*20 +: 20] = {4'(i), 15'h0, bcnt[i]};
                    req_last[i]          = bcnt[i];
                end
            end
            #1;
            if (c % 3 == 0) check($sformatf("rr%0d_grant", c), 32'(grant), 32'h0);
            else            check($sformatf("rr%0d_grant", c), 32'(grant), 32'(1) << order[(c / 3) % 3]);
            if (c == 0 || c % 3 == 1) begin
                check($sformatf("rr%0d_uv", c), 32'(uout_valid), 32'h0);
            end else begin
                check($sformatf("rr%0d_uv", c), 32'(uout_valid), 32'h1);
                if (c % 3 == 2) begin
                    own = order[(c / 3) % 3];
                    check($sformatf("rr%0d_uout", c), 32'(UOUT), 32'({4'(own), 16'h0000}));
                end else begin
                    own = order[(c / 3 - 1) % 3];
                    check($sformatf("rr%0d_uout", c), 32'(UOUT), 32'({4'(own), 16'h0001}));
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_ready[i]) bcnt[i] = ~bcnt[i];
            end
        end

        // MAX_BURST release after 8 beats, re-grant, then idle-timeout release
        // once requester 2 stops after 12 beats.
        reset_pulse();
        n = 0;
        for (int c = 0; c < 22; c++) begin
            @(negedge CLK);
            req_valid = (n < 12) ? 4'b0100 : 4'b0000;
            req_last  = '0;
            req_data  = '0;
            req_data[40 +: 20] = 20'h20000 + 20'(n + 1);
            #1;
            if ((c >= 1 && c <= 8) || (c >= 10 && c <= 17))
                check($sformatf("mb%0d_grant", c), 32'(grant), 32'h4);
            else
                check($sformatf("mb%0d_grant", c), 32'(grant), 32'h0);
            if (uout_valid) rx.push_back(UOUT);
            if (req_valid[2] && req_ready[2]) n++;
        end
        check("mb_rx_count", 32'(rx.size()), 32'd12);
        for (int k = 0; k < 12; k++) begin
            got = (k < rx.size()) ? rx[k] : 20'hFFFFF;
            check($sformatf("mb_rx%0d", k), 32'(got), 32'(20'h20000 + 20'(k + 1)));
        end

        // Asynchronous reset during requester 3's second beat, then UIN sync latency.
        reset_pulse();
        uout_ready = 1'b1;
        @(negedge CLK);
        req_valid = 4'b1000;
        req_data[60 +: 20] = 20'h30001;
        #1;
        check("ar_grant0", 32'(grant), 32'h0);
        @(negedge CLK);
        #1;
        check("ar_grant1", 32'(grant), 32'h8);
        @(negedge CLK);
        req_data[60 +: 20] = 20'h30002;
        #1;
        check("ar_uv", 32'(uout_valid), 32'h1);
        check("ar_uout", 32'(UOUT), 32'h30001);
        #2;
        resetn = 1'b0;
        UIN    = 20'hABCDE;
        #1;
        check_cleared("ar_clr");
        check("ar_sync_rst", 32'(uin_sync), 32'h0);
        @(negedge CLK);
        req_valid = '0;
        req_data  = '0;
        #1;
        check("ar_sync_held", 32'(uin_sync), 32'h0);
        resetn = 1'b1;
        @(posedge CLK);
        #1;
        check("ar_sync_1clk", 32'(uin_sync), 32'h0);
        @(posedge CLK);
        #1;
        check("ar_sync_2clk", 32'(uin_sync), 32'hABCDE);
        check("ar_grant_after", 32'(grant), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
